// File: rtl/glb_ld_dma_addr_gen.sv
// glb_ld_dma_addr_gen: nested-loop GLB read address generator for load DMA jobs,
// with optional active/inactive burst pacing and stall freeze.
package glb_ld_dma_pkg;
  localparam int GLB_ADDR_WIDTH = 22;
  localparam int CGRA_BYTE_OFFSET = 1;
  localparam int MAX_LOOP_LEVEL = 4;
  localparam int LOOP_W = 16;
  typedef struct packed {
    logic [LOOP_W-1:0] range;
    logic [LOOP_W-1:0] stride;
  } dma_iter_t;
  typedef struct packed {
    logic valid;
    logic [GLB_ADDR_WIDTH-1:0] start_addr;
    dma_iter_t [MAX_LOOP_LEVEL-1:0] iteration;
    logic [LOOP_W-1:0] num_active_words;
    logic [LOOP_W-1:0] num_inactive_words;
  } dma_ld_header_t;
  typedef struct packed {
    logic rd_en;
    logic [GLB_ADDR_WIDTH-1:0] rd_addr;
  } rdrq_packet_t;
endpackage

module glb_ld_dma_addr_gen
  import glb_ld_dma_pkg::*;
#(
  parameter int LOOP_LEVEL = 4,
  parameter int ADDR_W = GLB_ADDR_WIDTH
) (
  input  logic           clk,
  input  logic           reset_n,
  input  dma_ld_header_t ld_dma_header,
  input  logic           strm_start_pulse,
  input  logic           stall,
  output rdrq_packet_t   rdrq_packet,
  output logic           ld_dma_done_pulse,
  output logic           busy
);
  typedef enum logic [1:0] {IDLE, ACTIVE, INACTIVE} state_t;
  state_t state, state_nxt;
  dma_ld_header_t hdr;
  logic [LOOP_W-1:0] itr [LOOP_LEVEL];
  logic [LOOP_W-1:0] itr_nxt [LOOP_LEVEL];
  logic [LOOP_W-1:0] itr_max [LOOP_LEVEL];
  logic [LOOP_W-1:0] act_cnt, inact_cnt;
  logic [ADDR_W-1:0] offset;
  logic start, issue, last, carry, gap, inact_done;
  assign start = state == IDLE && strm_start_pulse && ld_dma_header.valid;
  assign issue = state == ACTIVE && hdr.valid && !stall;
  assign gap = hdr.num_active_words != '0 && hdr.num_inactive_words != '0 &&
               act_cnt + 1'b1 == hdr.num_active_words;
  assign inact_done = inact_cnt == hdr.num_inactive_words - 1'b1;
  // A range of 0 behaves as 1, so its iterator max is 0 either way.
  always_comb begin
    offset = '0;
    last = 1'b1;
    carry = 1'b1;
    for (int i = 0; i < LOOP_LEVEL; i++) begin
      itr_max[i] = hdr.iteration[i].range == '0 ? '0 : hdr.iteration[i].range - 1'b1;
      offset = offset + ADDR_W'(itr[i]) * ADDR_W'(hdr.iteration[i].stride);
      last = last & (itr[i] == itr_max[i]);
      itr_nxt[i] = carry ? (itr[i] == itr_max[i] ? '0 : itr[i] + 1'b1) : itr[i];
      carry = carry & (itr[i] == itr_max[i]);
    end
  end
  // Completion outranks the inactive gap so the last word has no trailing pause.
  always_comb begin
    state_nxt = start ? ACTIVE :
                issue && last ? IDLE :
                issue && gap ? INACTIVE :
                state == INACTIVE && !stall && inact_done ? ACTIVE : state;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      hdr <= '0;
      act_cnt <= '0;
      inact_cnt <= '0;
      for (int i = 0; i < LOOP_LEVEL; i++) itr[i] <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        hdr <= ld_dma_header;
        act_cnt <= '0;
        inact_cnt <= '0;
        for (int i = 0; i < LOOP_LEVEL; i++) itr[i] <= '0;
      end else if (issue) begin
        act_cnt <= gap ? '0 : act_cnt + 1'b1;
        inact_cnt <= '0;
        for (int i = 0; i < LOOP_LEVEL; i++) itr[i] <= itr_nxt[i];
      end else if (state == INACTIVE && !stall) begin
        inact_cnt <= inact_cnt + 1'b1;
      end
    end
  end
  assign rdrq_packet.rd_en = issue;
  assign rdrq_packet.rd_addr = issue ?
    GLB_ADDR_WIDTH'(ADDR_W'(hdr.start_addr) + (offset << CGRA_BYTE_OFFSET)) : '0;
  assign ld_dma_done_pulse = issue && last;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_glb_ld_dma_addr_gen.sv
// tb_glb_ld_dma_addr_gen: directed checks of address sequences, pacing, stall,
// wrap-around, ignored starts and asynchronous reset.
module tb_glb_ld_dma_addr_gen;
  import glb_ld_dma_pkg::*;
  logic clk = 1'b0;
  logic reset_n;
  dma_ld_header_t ld_dma_header;
  logic strm_start_pulse;
  logic stall;
  rdrq_packet_t rdrq_packet;
  logic ld_dma_done_pulse;
  logic busy;
  int total = 0;
  int bad = 0;

  glb_ld_dma_addr_gen dut (
    .clk(clk),
    .reset_n(reset_n),
    .ld_dma_header(ld_dma_header),
    .strm_start_pulse(strm_start_pulse),
    .stall(stall),
    .rdrq_packet(rdrq_packet),
    .ld_dma_done_pulse(ld_dma_done_pulse),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic dma_ld_header_t mk(input logic [21:0] sa, input logic [15:0] r0, s0, r1, s1,
                                        input logic [15:0] na, ni, input logic v = 1'b1);
    dma_ld_header_t h;
    h = '0;
    h.valid = v;
    h.start_addr = sa;
    h.iteration[0].range = r0;
    h.iteration[0].stride = s0;
    h.iteration[1].range = r1;
    h.iteration[1].stride = s1;
    h.num_active_words = na;
    h.num_inactive_words = ni;
    return h;
  endfunction

  task automatic chk(input string tag, input logic en, input logic [21:0] a,
                     input logic d, input logic b);
    total++;
    assert ({rdrq_packet.rd_en, rdrq_packet.rd_addr, ld_dma_done_pulse, busy} === {en, a, d, b})
    else begin
      bad++;
      $error("FAIL %s: got en=%0b addr=%h done=%0b busy=%0b, want en=%0b addr=%h done=%0b busy=%0b",
             tag, rdrq_packet.rd_en, rdrq_packet.rd_addr, ld_dma_done_pulse, busy, en, a, d, b);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #2;
  endtask

  task automatic req(input string tag, input logic [21:0] a, input logic d);
    #1 chk(tag, 1'b1, a, d, 1'b1);
    nxt();
  endtask

  task automatic hole(input string tag);
    #1 chk(tag, 1'b0, 22'h0, 1'b0, 1'b1);
    nxt();
  endtask

  task automatic idle(input string tag);
    #1 chk(tag, 1'b0, 22'h0, 1'b0, 1'b0);
    nxt();
  endtask

  task automatic start(input dma_ld_header_t h);
    ld_dma_header = h;
    strm_start_pulse = 1'b1;
    nxt();
    strm_start_pulse = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    ld_dma_header = '0;
    strm_start_pulse = 1'b0;
    stall = 1'b0;
    #1 chk("reset", 1'b0, 22'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    idle("post_reset");

    start(mk(22'h100, 16'd4, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0));
    req("lin0", 22'h100, 1'b0);
    req("lin1", 22'h102, 1'b0);
    req("lin2", 22'h104, 1'b0);
    req("lin3", 22'h106, 1'b1);
    idle("lin_end");

    start(mk(22'h0, 16'd2, 16'd1, 16'd3, 16'd8, 16'd0, 16'd0));
    req("nest0", 22'h00, 1'b0);
    req("nest1", 22'h02, 1'b0);
    req("nest2", 22'h10, 1'b0);
    req("nest3", 22'h12, 1'b0);
    req("nest4", 22'h20, 1'b0);
    req("nest5", 22'h22, 1'b1);
    idle("nest_end");

    start(mk(22'h0, 16'd6, 16'd1, 16'd1, 16'd0, 16'd2, 16'd3));
    req("pace0", 22'h0, 1'b0);
    req("pace1", 22'h2, 1'b0);
    repeat (3) hole("pace_gap_a");
    req("pace2", 22'h4, 1'b0);
    req("pace3", 22'h6, 1'b0);
    repeat (3) hole("pace_gap_b");
    req("pace4", 22'h8, 1'b0);
    req("pace5", 22'hA, 1'b1);
    idle("pace_end");

    start(mk(22'h40, 16'd4, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0));
    req("stl0", 22'h40, 1'b0);
    req("stl1", 22'h42, 1'b0);
    stall = 1'b1;
    repeat (5) hole("stl_hold");
    stall = 1'b0;
    req("stl2", 22'h44, 1'b0);
    req("stl3", 22'h46, 1'b1);
    idle("stl_end");

    start(mk(22'h3FFFFE, 16'd3, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0));
    req("wrap0", 22'h3FFFFE, 1'b0);
    req("wrap1", 22'h000000, 1'b0);
    req("wrap2", 22'h000002, 1'b1);
    idle("wrap_end");

    start(mk(22'h700, 16'd2, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 1'b0));
    idle("novalid0");
    idle("novalid1");

    start(mk(22'h200, 16'd3, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0));
    req("busy0", 22'h200, 1'b0);
    ld_dma_header = mk(22'h500, 16'd8, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0);
    strm_start_pulse = 1'b1;
    req("busy1", 22'h202, 1'b0);
    strm_start_pulse = 1'b0;
    req("busy2", 22'h204, 1'b1);
    idle("busy_end");

    start(mk(22'h300, 16'd8, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0));
    req("rst0", 22'h300, 1'b0);
    req("rst1", 22'h302, 1'b0);
    reset_n = 1'b0;
    #1 chk("rst_async", 1'b0, 22'h0, 1'b0, 1'b0);
    nxt();
    idle("rst_held");
    reset_n = 1'b1;
    idle("rst_release");
    start(mk(22'h010, 16'd2, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0));
    req("after_rst0", 22'h010, 1'b0);
    req("after_rst1", 22'h012, 1'b1);
    idle("after_rst_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
